// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the parity helper.
// UART_TX_PARITY_EN adds the PARITY state used by the 8E1 frame format.
package uart_pkg;

  localparam int   UART_DATA_BITS       = 8;
  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   UART_CLK_PER_BIT_DEF = 5208;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } uart_state_e;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(ADDR_WIDTH+1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      count_r  <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (ADDR_WIDTH+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_WIDTH+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: queues bytes over valid/ready and sends 8N1 frames LSB first.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit between data and stop).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEF,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic [7:0]            din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  txd,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                  CNT_W      = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [2:0]          LAST_BIT   = 3'(UART_DATA_BITS - 1);

  uart_state_e                state_r;
  logic [CNT_W-1:0]           bit_cnt_r;
  logic [2:0]                 bit_idx_r;
  logic [UART_DATA_BITS-1:0]  sreg_r;
  logic                       txd_r;
  logic                       din_ready_r;
  logic                       busy_r;
`ifdef UART_TX_PARITY_EN
  logic                       parity_r;
`endif

  logic [7:0]                 fifo_rdata_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [ADDR_WIDTH:0]        fifo_count_s;
  logic [ADDR_WIDTH:0]        count_next_s;
  logic                       bit_end_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       stay_active_s;

  uart_sync_fifo #(
    .WIDTH      (UART_DATA_BITS),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_X),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (din),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Handshake, pop decision and next-cycle occupancy
  always_comb begin
    bit_end_s     = (bit_cnt_r == {CNT_W{1'b0}});
    push_s        = din_valid && din_ready_r && !fifo_full_s;
    pop_s         = 1'b0;
    stay_active_s = 1'b0;
    if (state_r == ST_IDLE) begin
      pop_s = !fifo_empty_s;
    end else if ((state_r == ST_STOP) && bit_end_s) begin
      pop_s = !fifo_empty_s;
    end else begin
      stay_active_s = 1'b1;
    end
    count_next_s = fifo_count_s + (ADDR_WIDTH+1)'(push_s) - (ADDR_WIDTH+1)'(pop_s);
  end

  // Ready and busy are registered from next-cycle values so they line up with count and state
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      din_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      din_ready_r <= (count_next_s < DEPTH_C);
      busy_r      <= stay_active_s || pop_s || (count_next_s != {(ADDR_WIDTH+1){1'b0}});
    end
  end

  // Serialiser FSM; every non-idle state lasts CLK_PER_BIT cycles via the down-counter
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_r   <= ST_IDLE;
      txd_r     <= UART_IDLE_LEVEL;
      bit_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r <= 3'd0;
      sreg_r    <= {UART_DATA_BITS{1'b0}};
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          txd_r <= UART_IDLE_LEVEL;
          if (pop_s) begin
            sreg_r    <= fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= even_parity(fifo_rdata_s);
`endif
            txd_r     <= 1'b0;
            bit_cnt_r <= CNT_RELOAD;
            state_r   <= ST_START;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_START: begin
          if (!bit_end_s) begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end else begin
            txd_r     <= sreg_r[0];
            sreg_r    <= sreg_r >> 1;
            bit_idx_r <= 3'd0;
            bit_cnt_r <= CNT_RELOAD;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!bit_end_s) begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end else if (bit_idx_r != LAST_BIT) begin
            txd_r     <= sreg_r[0];
            sreg_r    <= sreg_r >> 1;
            bit_idx_r <= bit_idx_r + 3'd1;
            bit_cnt_r <= CNT_RELOAD;
          end else begin
            bit_cnt_r <= CNT_RELOAD;
`ifdef UART_TX_PARITY_EN
            txd_r     <= parity_r;
            state_r   <= ST_PARITY;
`else
            txd_r     <= UART_IDLE_LEVEL;
            state_r   <= ST_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (!bit_end_s) begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end else begin
            txd_r     <= UART_IDLE_LEVEL;
            bit_cnt_r <= CNT_RELOAD;
            state_r   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (!bit_end_s) begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end else if (pop_s) begin
            // Next byte already queued: start bit follows the stop bit directly
            sreg_r    <= fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= even_parity(fifo_rdata_s);
`endif
            txd_r     <= 1'b0;
            bit_cnt_r <= CNT_RELOAD;
            state_r   <= ST_START;
          end else begin
            txd_r     <= UART_IDLE_LEVEL;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          txd_r     <= UART_IDLE_LEVEL;
          bit_cnt_r <= {CNT_W{1'b0}};
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign din_ready = din_ready_r;
  assign txd       = txd_r;
  assign busy      = busy_r;
  assign count     = fifo_count_s;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: accepted bytes are queued, a loopback receiver pops and compares.
// Honours UART_TX_PARITY_EN to expect 8E1 frames.
module tb_uart_tx_buffered;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME     = CPB * NBITS;
  localparam int STOP_TICK = HALF + CPB * (NBITS - 1);

  logic       clk = 1'b0;
  logic       rst_x;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       txd;
  logic       busy;
  logic [4:0] count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  logic       mon_active = 1'b0;
  int         mon_tick   = 0;
  logic [7:0] mon_data   = 8'h00;
  logic       mon_par    = 1'b0;
  logic       last_par   = 1'b0;

  uart_tx_buffered #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (16),
    .ADDR_WIDTH  (4)
  ) dut (
    .CLK       (clk),
    .RST_X     (rst_x),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .txd       (txd),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Loopback receiver: samples mid-bit and checks each frame against the scoreboard
  always @(negedge clk) begin
    if (!rst_x) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (txd == 1'b0) begin
        mon_active = 1'b1;
        mon_tick   = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_tick++;
      if (mon_tick == HALF) chk("start_bit", {31'd0, txd}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        if (mon_tick == HALF + CPB * (i + 1)) mon_data[i] = txd;
      end
      if (mon_tick == HALF + CPB * 9) mon_par = txd;
      if (mon_tick == STOP_TICK) begin
        chk("stop_bit", {31'd0, txd}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=%02h required=none", mon_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("rx_byte", {24'd0, mon_data}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
          chk("rx_parity", {31'd0, mon_par}, {31'd0, ^e});
`endif
          last_par = mon_par;
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, output logic acc, output int pe);
    @(negedge clk);
    din       = b;
    din_valid = 1'b1;
    acc       = din_ready;
    pe        = cyc + 1;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic release_in();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !mon_active) done = 1'b1;
    end
    chk("idle_reached", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic acc;
    int   pe, s, n, idx, n0, low_cnt;
    logic stalled;

    rst_x = 1'b0; din = 8'h00; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    rst_x = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, din_ready}, 32'd1);

    // Single byte: latency, frame length, busy fall
    drive_byte(8'hA5, acc, pe);
    chk("single_accept", {31'd0, acc}, 32'd1);
    release_in();
    chk("pre_start_txd", {31'd0, txd}, 32'd1);
    s = pe + 1;
    while (cyc < s) @(negedge clk);
    chk("start_latency", {31'd0, txd}, 32'd0);
    while (cyc < s + FRAME - 1) @(negedge clk);
    chk("busy_last_stop", {31'd0, busy}, 32'd1);
    chk("txd_last_stop", {31'd0, txd}, 32'd1);
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("count_empty", {27'd0, count}, 32'd0);
    wait_idle(50);

    // Burst behind a frame in flight: three queued, then back-to-back
    drive_byte(8'h11, acc, pe);
    release_in();
    repeat (3) @(negedge clk);
    drive_byte(8'h00, acc, pe);
    drive_byte(8'hFF, acc, pe);
    drive_byte(8'h55, acc, pe);
    release_in();
    chk("burst_count", {27'd0, count}, 32'd3);
    wait_idle(1500);
    n = start_q.size();
    if (n >= 4) begin
      chk("b2b_gap1", start_q[n-3] - start_q[n-4], FRAME);
      chk("b2b_gap2", start_q[n-2] - start_q[n-3], FRAME);
      chk("b2b_gap3", start_q[n-1] - start_q[n-2], FRAME);
      chk("burst_span", start_q[n-1] + FRAME - start_q[n-3], 3 * FRAME);
    end else begin
      checks++; failures++;
      $display("FAIL burst_frames actual=%0d required=4", n);
    end

    // Full FIFO: hold valid across 20 bytes
    idx = 0; stalled = 1'b0;
    for (int b = 0; b < 5000 && idx < 20; b++) begin
      @(negedge clk);
      din       = 8'hC0 + 8'(idx);
      din_valid = 1'b1;
      if (din_ready) begin
        exp_q.push_back(din);
        idx++;
      end else if (!stalled) begin
        stalled = 1'b1;
        chk("full_accepted", idx, 32'd17);
        chk("full_count", {27'd0, count}, 32'd16);
      end
    end
    release_in();
    chk("full_all_taken", idx, 32'd20);
    wait_idle(4000);

    // Push on the very edge the FSM pops with one byte queued
    drive_byte(8'h81, acc, pe);
    release_in();
    drive_byte(8'h42, acc, pe);
    release_in();
    chk("simul_pre_count", {27'd0, count}, 32'd1);
    s = pe - 1;
    while (cyc < s + FRAME - 1) @(negedge clk);
    din = 8'h7E; din_valid = 1'b1;
    chk("simul_ready", {31'd0, din_ready}, 32'd1);
    if (din_ready) exp_q.push_back(din);
    @(negedge clk);
    din_valid = 1'b0;
    chk("simul_count", {27'd0, count}, 32'd1);
    chk("simul_start", {31'd0, txd}, 32'd0);
    wait_idle(1000);

    // Reset mid-frame at bit 3 of 0x3C with four bytes queued
    drive_byte(8'h3C, acc, pe);
    s = pe + 1;
    drive_byte(8'h01, acc, pe);
    drive_byte(8'h02, acc, pe);
    drive_byte(8'h03, acc, pe);
    drive_byte(8'h04, acc, pe);
    release_in();
    while (cyc < s + CPB * 4 + HALF) @(negedge clk);
    chk("pre_rst_count", {27'd0, count}, 32'd4);
    rst_x = 1'b0;
    #1;
    chk("mid_rst_txd", {31'd0, txd}, 32'd1);
    chk("mid_rst_count", {27'd0, count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, din_ready}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    n0 = start_q.size();
    rst_x = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'd0, din_ready}, 32'd1);
    low_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd == 1'b0) low_cnt++;
    end
    chk("post_rst_quiet", low_cnt, 32'd0);
    chk("post_rst_frames", start_q.size(), n0);

`ifdef UART_TX_PARITY_EN
    drive_byte(8'h07, acc, pe);
    release_in();
    wait_idle(400);
    chk("par_07", {31'd0, last_par}, 32'd1);
    drive_byte(8'h03, acc, pe);
    release_in();
    wait_idle(400);
    chk("par_03", {31'd0, last_par}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
FIFO-buffered UART transmitter: the serial source for the existing UART receiver on the far end of the link. It accepts bytes over a valid/ready handshake and serialises 8N1 frames (LSB first) on txd. The block replaces the blocking enable/ready transmitter where a thread must queue several bytes without stalling. It sits between thread logic and the board's TX pin.

Parameters:
CLK_PER_BIT, 5208, clock cycles per bit; 100 MHz / 19200 baud; legal minimum 2.
FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
ADDR_WIDTH, 4, log2(FIFO_DEPTH); must match FIFO_DEPTH.

Ports:
CLK  input  1  clock; all logic on posedge.
RST_X  input  1  reset, asynchronous, active-low.
din  input  8  byte to send.
din_valid  input  1  din is presented this cycle.
din_ready  output  1  registered; FIFO can accept a byte this cycle.
txd  output  1  registered serial line; idle high.
busy  output  1  high while the FIFO is non-empty or a frame is in flight.
count  output  ADDR_WIDTH+1  FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (RST_X low, asynchronous): txd=1, din_ready=0, busy=0, count=0, FIFO pointers 0, FSM=IDLE, bit counter 0. On the first edge after release, din_ready becomes 1.
- Reset mid-frame: the line returns high immediately, the partial frame is truncated and queued bytes are discarded.
- Push: occurs on an edge where din_valid && din_ready. din_ready next = (count_next < FIFO_DEPTH). A full FIFO never accepts, so no overflow is possible. din_valid while din_ready=0 is ignored with no side effect.
- Pop: performed by the FSM only, in the cases below. A push and a pop on the same edge leave count unchanged. A pop frees a slot that is visible via din_ready on the following cycle.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the option). Every state except IDLE holds txd for exactly CLK_PER_BIT cycles, timed by a down-counter reloaded with CLK_PER_BIT-1.
- IDLE:
  - txd=1.
  - If the FIFO is non-empty: pop, load the shift register, set txd<=0, go to START.
- START -> DATA: txd<=sreg[0], bit index 0.
- DATA:
  - Shift right at each bit boundary.
  - After bit 7's period, go to STOP with txd<=1.
- STOP end, FIFO non-empty: pop and go to START with txd<=0, giving back-to-back frames with no idle gap.
- STOP end, FIFO empty: go to IDLE.
- Frame length: exactly 10*CLK_PER_BIT cycles.
- Latency: a byte pushed into an empty, idle block at edge k drives txd low after edge k+1.
- busy = (state != IDLE) || (count != 0), registered-equivalent; low only when the line is idle and the FIFO is empty.
- Pointers wrap modulo FIFO_DEPTH. count saturates naturally at FIFO_DEPTH because of the ready gating.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: a PARITY state sits between DATA and STOP and drives the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles. The frame is 8E1, 11*CLK_PER_BIT cycles.
- Undefined: 8N1 as above; the PARITY state and its logic are absent.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding;
  - UART_DATA_BITS=8;
  - UART_IDLE_LEVEL=1;
  - the default CLK_PER_BIT.
  The existing receiver can share these.
- Sub-module uart_sync_fifo: a synchronous single-clock FIFO (push/pop, full/empty, count), parameterised by width and depth, asynchronous active-low reset. The serialiser FSM stays in the top.

Test Plan:
- Single byte (bench CLK_PER_BIT=16): push 0xA5 when idle -> txd low 1 cycle after push. Then LSB-first bits 1,0,1,0,0,1,0,1 at 16 cycles each, stop high for 16 cycles, busy falls after 160 cycles. The loopback receiver returns 0xA5.
- Burst: push 0x00,0xFF,0x55 on consecutive cycles -> count reaches 3. Three frames back-to-back, total 480 cycles, with no idle cycle between stop and start.
- Full FIFO: hold din_valid with 20 distinct bytes (FIFO_DEPTH=16) -> din_ready drops at count=16. Only accepted bytes are transmitted, in order, with no loss or duplication.
- Simultaneous push/pop: push exactly on the edge the FSM pops, with count=1 -> count stays 1 and both bytes are sent in order.
- Reset mid-frame: assert RST_X low at bit 3 of 0x3C with 4 bytes queued -> txd=1 and count=0 asynchronously. After release, din_ready=1 on the next edge and nothing is transmitted.
- Parity build (UART_TX_PARITY_EN): send 0x07 -> parity bit 1, frame 176 cycles. Send 0x03 -> parity bit 0.
